led_seq_scheduler: RTL and testbench
====================================

Name: led_seq_scheduler

Overview:
Command-driven sequencer for the board LED bank. Accepts pattern commands over a valid/ready handshake, times each step with a prescaler, and generates left-flow, right-flow and blink patterns for a bounded or unbounded number of cycles. It sits between a host or control FSM and the LED pins, replacing free-running flow logic with a schedulable, preemptable controller.

Parameters:
LED_W, 8, number of LEDs driven
PRESCALE, 50000, sys_clk cycles per time unit (1 ms at 50 MHz); must be >= 1
PERIOD_W, 16, width of the step-period field

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted this cycle
cmd_mode  in  2  00 OFF, 01 FLOW_L, 10 FLOW_R, 11 BLINK
cmd_period  in  PERIOD_W  time units per step; 0 is treated as 1
cmd_repeat  in  8  full pattern cycles to run; 0 means run until preempted
led_out  out  LED_W  registered LED drive, 1 = lit
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse when a finite command completes or OFF executes

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values: led_out=0, busy=0, done=0, cmd_ready=1, FSM=IDLE, all counters 0, latched command cleared.
- Accept: a command is accepted on a rising edge where cmd_valid && cmd_ready. Mode, period and repeat are latched on that edge.
- cmd_ready: 1 in IDLE. In RUN, 1 only while the latched repeat is 0. It is 0 in LOAD and DONE.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE to LOAD on accept.
  - LOAD to RUN after 1 cycle. Entering RUN, led_out takes the initial pattern and the prescaler and step counters clear.
  - OFF: LOAD goes to DONE and led_out is set to 0.
  - RUN to LOAD on accept (preemption). No done pulse is issued for the preempted command.
  - RUN to DONE on the final step tick.
  - DONE to IDLE after 1 cycle, with done=1 and led_out=0 during DONE.
- Latency: accept at edge N puts LOAD after edge N, and the initial pattern is visible after edge N+1.
- Step tick: fires every max(period,1)*PRESCALE cycles in RUN. The first tick comes that many cycles after entering RUN.
- Patterns:
  - FLOW_L starts at 0..01 and rotates left each tick; a cycle is LED_W steps.
  - FLOW_R starts at 10..0 and rotates right; a cycle is LED_W steps.
  - BLINK starts all-ones and inverts each tick; a cycle is 2 steps.
- Termination: a step counter counts ticks. When it reaches repeat*cycle_len, that tick moves to DONE instead of advancing the pattern. Width is 8+log2(LED_W) bits with no overflow.
- Wrap: rotation wraps MSB to LSB and back. With repeat=0 the step counter is held at 0, so it never wraps.
- Reset mid-operation: reset wins over any accept in the same cycle. The pending command is dropped and no done pulse is issued.
- cmd_valid held during LOAD or DONE waits. It is accepted in IDLE on the cycle after DONE.

Optional Feature:
LED_PWM_DIM_EN.
- Defined:
  - Adds input cmd_duty [3:0], latched on accept.
  - Adds a free-running 4-bit pwm counter, reset to 0.
  - led_out = pattern & {LED_W{pwm_cnt < duty}}. Duty 0 keeps the LEDs dark; duty 15 gives 15/16 brightness.
  - DONE and OFF still force 0.
- Undefined: no cmd_duty port and no pwm counter; led_out = pattern.

Decomposition:
- Package led_seq_pkg:
  - mode encodings MODE_OFF, MODE_FLOW_L, MODE_FLOW_R, MODE_BLINK
  - FSM state enum
  - default LED_W
  - cycle-length constants
- Sub-module led_tick_gen:
  - contains the prescaler and period counter
  - inputs: clear and period
  - output: single-cycle step_tick

Test Plan (PRESCALE=4, LED_W=8):
1. Hold sys_rst 3 cycles with cmd_valid=1 -> led_out=0x00, busy=0, done=0, cmd_ready=1; no accept during reset.
2. FLOW_L, period=2, repeat=1 -> led_out 0x01 two edges after accept, then 0x02, 0x04 … 0x80 every 8 cycles. The 8th tick gives DONE with done=1 for 1 cycle and led_out=0x00, then IDLE with cmd_ready=1.
3. FLOW_R, period=1, repeat=2 -> 0x80 down to 0x01 twice with a step every 4 cycles, then done after exactly 16 ticks (64 RUN cycles).
4. BLINK, period=0, repeat=3 -> treated as period 1; 0xFF and 0x00 alternate every 4 cycles for 6 ticks, then a done pulse.
5. FLOW_L with repeat=0; after 3 ticks (led_out=0x08) issue FLOW_R, period=1, repeat=1 -> accepted immediately, led_out=0x80 two edges later, no done pulse for the first command. cmd_ready=0 until the second command finishes.
6. Assert sys_rst mid-RUN -> led_out=0x00 and IDLE after that edge, no done. Separately, holding cmd_valid through DONE -> accepted on the first IDLE cycle.

Source files
------------

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED sequence scheduler.
//   - mode_e  : command mode encodings (OFF, FLOW_L, FLOW_R, BLINK)
//   - state_e : scheduler FSM states
//   - DEFAULT_LED_W, BLINK_CYCLE_LEN: sizing and pattern-cycle constants
// Flow patterns use one step per LED, so their cycle length is LED_W and
// is computed where LED_W is known.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_FLOW_L = 2'b01,
    MODE_FLOW_R = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEFAULT_LED_W   = 8;
  localparam int BLINK_CYCLE_LEN = 2;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step timer for the LED scheduler.
// A prescaler divides sys_clk into time units of PRESCALE cycles; a unit
// counter then emits one step_tick every max(period,1) units.
// Ports:
//   sys_clk   in   clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   clear     in   holds both counters at 0 (used outside RUN)
//   period    in   time units per step; 0 behaves as 1
//   step_tick out  single-cycle pulse on the last cycle of each step
module led_tick_gen #(
  parameter int PRESCALE = 50000,
  parameter int PERIOD_W = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                step_tick
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt;
  logic [PERIOD_W-1:0] unit_cnt;
  logic [PERIOD_W-1:0] last_unit;
  logic                unit_tick;

  // period 0 and period 1 both mean a single unit per step
  assign last_unit = (period == '0) ? '0 : (period - PERIOD_W'(1));
  assign unit_tick = (pre_cnt == PRE_MAX);
  assign step_tick = !clear && unit_tick && (unit_cnt == last_unit);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end else if (unit_tick) begin
      pre_cnt  <= '0;
      unit_cnt <= (unit_cnt == last_unit) ? '0 : (unit_cnt + PERIOD_W'(1));
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_scheduler.sv
// led_seq_scheduler: command-driven LED pattern sequencer.
// Accepts FLOW_L / FLOW_R / BLINK / OFF commands, times each step through
// led_tick_gen, and runs a pattern for cmd_repeat full cycles (0 = until a
// new command preempts it).
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; mode/period/repeat are latched on that edge.
// cmd_ready does not depend on cmd_valid. A held cmd_valid simply waits.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_mode/period/repeat  command fields
//   cmd_duty                PWM duty, only when LED_PWM_DIM_EN is defined
//   led_out                 LED drive, 1 = lit
//   busy                    high in LOAD and RUN
//   done                    one-cycle pulse (DONE state)
//   state_dbg               current FSM state (state_e encoding)
// Optional feature macro: LED_PWM_DIM_EN (duty-cycle dimming of led_out).
module led_seq_scheduler
  import led_seq_pkg::*;
#(
  parameter int LED_W    = DEFAULT_LED_W,
  parameter int PRESCALE = 50000,
  parameter int PERIOD_W = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [7:0]          cmd_repeat,
  output logic [LED_W-1:0]    led_out,
  output logic                busy,
  output logic                done,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]          cmd_duty,
`endif
  output logic [1:0]          state_dbg
);

  localparam int STEP_W = 8 + $clog2(LED_W);

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [7:0]          repeat_q;
  logic [LED_W-1:0]    pattern_q, pattern_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   cycle_len;
  logic [STEP_W-1:0]   target;
  logic [LED_W-1:0]    init_pattern;
  logic [LED_W-1:0]    next_pattern;
  logic                accept;
  logic                final_step;
  logic                step_tick;

  led_tick_gen #(
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .clear     (state_q != ST_RUN),
    .period    (period_q),
    .step_tick (step_tick)
  );

  assign accept = cmd_valid && cmd_ready;

  // Termination: the tick that would make the count reach repeat*cycle_len
  // ends the command instead of advancing the pattern.
  assign cycle_len  = (mode_q == MODE_BLINK) ? STEP_W'(BLINK_CYCLE_LEN) : STEP_W'(LED_W);
  assign target     = STEP_W'(repeat_q) * cycle_len;
  assign final_step = (repeat_q != 8'd0) && ((step_q + STEP_W'(1)) == target);

  always_comb begin
    init_pattern = '0;
    next_pattern = pattern_q;
    case (mode_q)
      MODE_FLOW_L: begin
        init_pattern = LED_W'(1);
        next_pattern = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
      end
      MODE_FLOW_R: begin
        init_pattern = LED_W'(1) << (LED_W - 1);
        next_pattern = {pattern_q[0], pattern_q[LED_W-1:1]};
      end
      MODE_BLINK: begin
        init_pattern = '1;
        next_pattern = ~pattern_q;
      end
      default: begin
        init_pattern = '0;
        next_pattern = '0;
      end
    endcase
  end

  // FSM next state, datapath next values and handshake/status outputs
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    step_d    = step_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (mode_q == MODE_OFF) begin
          state_d   = ST_DONE;
          pattern_d = '0;
        end else begin
          state_d   = ST_RUN;
          pattern_d = init_pattern;
          step_d    = '0;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        // only an unbounded command may be preempted
        cmd_ready = (repeat_q == 8'd0);
        if (accept) begin
          state_d = ST_LOAD;
        end else if (step_tick) begin
          if (final_step) begin
            state_d   = ST_DONE;
            pattern_d = '0;
          end else begin
            pattern_d = next_pattern;
            if (repeat_q != 8'd0) step_d = step_q + STEP_W'(1);
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_d   = ST_IDLE;
        pattern_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pattern_q <= '0;
      step_q    <= '0;
      mode_q    <= MODE_OFF;
      period_q  <= '0;
      repeat_q  <= '0;
    end else begin
      pattern_q <= pattern_d;
      step_q    <= step_d;
      if (accept) begin
        mode_q   <= mode_e'(cmd_mode);
        period_q <= cmd_period;
        repeat_q <= cmd_repeat;
      end
    end
  end

  assign state_dbg = state_q;

`ifdef LED_PWM_DIM_EN
  logic [3:0] duty_q;
  logic [3:0] pwm_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      duty_q  <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      if (accept) duty_q <= cmd_duty;
    end
  end

  // pattern_q is already 0 in DONE and after OFF, so those stay dark
  assign led_out = pattern_q & {LED_W{pwm_cnt < duty_q}};
`else
  assign led_out = pattern_q;
`endif

endmodule

// File: tb/tb_led_seq_scheduler.sv
// tb_led_seq_scheduler: self-checking bench for led_seq_scheduler
// (PRESCALE=4, LED_W=8). Each accepted command pushes its expected
// {cycle, done, led_out} events to exp_q; a negedge monitor pops and
// compares whenever {done, led_out} changes.
module tb_led_seq_scheduler;
  import led_seq_pkg::*;

  localparam int PRESCALE = 4;
  localparam int PERIOD_W = 16;
  localparam int W        = 41;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [PERIOD_W-1:0] cmd_period;
  logic [7:0]          cmd_repeat;
  logic [7:0]          led_out;
  logic                busy;
  logic                done;
  logic [1:0]          state_dbg;
`ifdef LED_PWM_DIM_EN
  logic [3:0]          cmd_duty = 4'hF;
`endif

  logic [W-1:0] exp_q[$];
  logic [31:0]  cyc = '0;
  logic [8:0]   prev_obs;
  logic         mon_en = 1'b0;
  int           n_cmp = 0;
  int           n_err = 0;

  led_seq_scheduler #(
    .LED_W    (8),
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .cmd_repeat (cmd_repeat),
    .led_out    (led_out),
    .busy       (busy),
    .done       (done),
`ifdef LED_PWM_DIM_EN
    .cmd_duty   (cmd_duty),
`endif
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pat(input mode_e m, input int k);
    logic [7:0] lsb_one = 8'h01;
    logic [7:0] msb_one = 8'h80;
    case (m)
      MODE_FLOW_L: return lsb_one << (k % 8);
      MODE_FLOW_R: return msb_one >> (k % 8);
      default:     return ((k % 2) == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Expected events for a command accepted on edge acc. max_ev caps the
  // number of pattern events (preempted, reset or unbounded commands).
  task automatic push_cmd(input int acc, input mode_e m, input int period,
                          input int rep, input int max_ev);
    int s, len, tot, n_pat;
    if (m == MODE_OFF) begin
      exp_q.push_back({32'(acc + 1), 1'b1, 8'h00});
      exp_q.push_back({32'(acc + 2), 1'b0, 8'h00});
      return;
    end
    s     = ((period == 0) ? 1 : period) * PRESCALE;
    len   = (m == MODE_BLINK) ? 2 : 8;
    tot   = rep * len;
    n_pat = (rep == 0 || max_ev < tot) ? max_ev : tot;
    for (int k = 0; k < n_pat; k++)
      exp_q.push_back({32'(acc + 1 + k * s), 1'b0, exp_pat(m, k)});
    if (rep != 0 && max_ev >= tot) begin
      exp_q.push_back({32'(acc + 1 + tot * s), 1'b1, 8'h00});
      exp_q.push_back({32'(acc + 2 + tot * s), 1'b0, 8'h00});
    end
  endtask

  // Drives a command from a negedge and waits (bounded) for cmd_ready.
  // Returns after the accepting posedge; cmd_valid is left high.
  task automatic send_cmd(input mode_e m, input int period, input int rep,
                          output int acc, output int waited);
    logic got = 1'b0;
    waited = 0;
    acc    = 0;
    @(negedge sys_clk);
    cmd_valid  = 1'b1;
    cmd_mode   = m;
    cmd_period = PERIOD_W'(period);
    cmd_repeat = 8'(rep);
    while (!got && waited < 500) begin
      if (cmd_ready) begin
        got = 1'b1;
        acc = int'(cyc) + 1;
      end else begin
        @(negedge sys_clk);
        waited++;
      end
    end
    check_val("accept_seen", 64'(got), 64'd1);
    @(posedge sys_clk);
  endtask

  // Drops cmd_valid and checks LOAD then RUN status.
  task automatic check_flags(input int rep);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    check_val("load_state", 64'(state_dbg), 64'(ST_LOAD));
    check_val("load_ready", 64'(cmd_ready), 64'd0);
    check_val("load_busy",  64'(busy),      64'd1);
    @(negedge sys_clk);
    check_val("run_state",  64'(state_dbg), 64'(ST_RUN));
    check_val("run_ready",  64'(cmd_ready), 64'(rep == 0));
    check_val("run_busy",   64'(busy),      64'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    check_val("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // scoreboard monitor: compare on every change of {done, led_out}
  always @(negedge sys_clk) begin
    logic [8:0]   cur;
    logic [W-1:0] e;
    if (mon_en) begin
      cur = {done, led_out};
      if (cur !== prev_obs) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_evt", 64'({cyc, cur}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("event", 64'({cyc, cur}), 64'(e));
        end
      end
      prev_obs = cur;
    end
  end

  initial begin
    int a, b, w;
    // reset held 3 cycles with cmd_valid high: nothing accepted
    sys_rst    = 1'b1;
    cmd_valid  = 1'b1;
    cmd_mode   = MODE_FLOW_L;
    cmd_period = PERIOD_W'(1);
    cmd_repeat = 8'd1;
    repeat (3) begin
      @(negedge sys_clk);
      check_val("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      check_val("rst_led",   64'(led_out),   64'h00);
    end
    check_val("rst_busy",  64'(busy),      64'd0);
    check_val("rst_done",  64'(done),      64'd0);
    check_val("rst_ready", 64'(cmd_ready), 64'd1);
    sys_rst   = 1'b0;
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    check_val("post_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    prev_obs = {done, led_out};
    mon_en   = 1'b1;

    // FLOW_L, period 2, repeat 1
    send_cmd(MODE_FLOW_L, 2, 1, a, w);
    check_val("t2_wait", 64'(w), 64'd0);
    push_cmd(a, MODE_FLOW_L, 2, 1, 1000);
    check_flags(1);
    wait_drain(200);
    check_val("t2_idle_ready", 64'(cmd_ready), 64'd1);

    // FLOW_R, period 1, repeat 2
    send_cmd(MODE_FLOW_R, 1, 2, a, w);
    check_val("t3_wait", 64'(w), 64'd0);
    push_cmd(a, MODE_FLOW_R, 1, 2, 1000);
    check_flags(2);
    wait_drain(200);

    // BLINK, period 0 (treated as 1), repeat 3
    send_cmd(MODE_BLINK, 0, 3, a, w);
    check_val("t4_wait", 64'(w), 64'd0);
    push_cmd(a, MODE_BLINK, 0, 3, 1000);
    check_flags(3);
    wait_drain(200);

    // OFF: straight to DONE
    send_cmd(MODE_OFF, 1, 0, a, w);
    check_val("off_wait", 64'(w), 64'd0);
    push_cmd(a, MODE_OFF, 1, 0, 1000);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    wait_drain(50);

    // unbounded FLOW_L preempted after 3 ticks by FLOW_R
    send_cmd(MODE_FLOW_L, 1, 0, a, w);
    push_cmd(a, MODE_FLOW_L, 1, 0, 4);
    check_flags(0);
    wait_drain(200);
    send_cmd(MODE_FLOW_R, 1, 1, b, w);
    check_val("t5_preempt_acc", 64'(b), 64'(a + 15));
    push_cmd(b, MODE_FLOW_R, 1, 1, 1000);
    check_flags(1);
    wait_drain(200);

    // reset mid-RUN: LEDs off, IDLE, no done pulse
    send_cmd(MODE_FLOW_L, 1, 1, a, w);
    push_cmd(a, MODE_FLOW_L, 1, 1, 3);
    check_flags(1);
    wait_drain(200);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    exp_q.push_back({cyc + 32'd1, 1'b0, 8'h00});
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check_val("t6_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check_val("t6_rst_busy",  64'(busy),      64'd0);
    check_val("t6_rst_ready", 64'(cmd_ready), 64'd1);
    wait_drain(20);

    // cmd_valid held through DONE: accepted on the first IDLE cycle
    send_cmd(MODE_BLINK, 1, 1, a, w);
    push_cmd(a, MODE_BLINK, 1, 1, 1000);
    send_cmd(MODE_FLOW_L, 1, 1, b, w);
    check_val("t6_held_acc", 64'(b), 64'(a + 11));
    push_cmd(b, MODE_FLOW_L, 1, 1, 1000);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    wait_drain(200);

    // quiet tail: any stray event is reported by the monitor
    repeat (20) @(negedge sys_clk);
    check_val("final_state", 64'(state_dbg), 64'(ST_IDLE));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
